// File: rtl/mem_arbiter_if.sv
// Cache-miss and block-memory signals seen by the arbiter between the I/D caches and memory.
// master is the arbiter's view; slave is the view of the surrounding caches and memory.
interface mem_arbiter_if #(
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128
);
    logic               i_read;
    logic [ADDR_W-1:0]  i_addr;
    logic [BLOCK_W-1:0] i_rdata;
    logic               i_ready;

    logic               d_read;
    logic               d_write;
    logic [ADDR_W-1:0]  d_addr;
    logic [BLOCK_W-1:0] d_wdata;
    logic [BLOCK_W-1:0] d_rdata;
    logic               d_ready;

    logic               mem_read;
    logic               mem_write;
    logic [ADDR_W-1:0]  mem_addr;
    logic [BLOCK_W-1:0] mem_wdata;
    logic [BLOCK_W-1:0] mem_rdata;
    logic               mem_ready;

    modport master (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one block-memory port between the I cache (read-only) and the D cache (read/write).
// One transaction at a time; the winner's command is latched and held until mem_ready.
module mem_arbiter #(
    parameter int ADDR_W     = 28,
    parameter int BLOCK_W    = 128,
    parameter int D_PRIORITY = 0
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.master   bus,
    output logic            grant_d,
    output logic            busy
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t             state;
    logic               last_grant_d;
    logic               op_write;
    logic [ADDR_W-1:0]  addr_q;
    logic [BLOCK_W-1:0] wdata_q;

    logic want_i;
    logic want_d;
    logic pick_d;
    logic serve_i;
    logic serve_d;
    logic i_done;
    logic d_done;

    assign want_i = bus.i_read;
    assign want_d = bus.d_read | bus.d_write;

    // On a conflict, round-robin hands the port to whichever side did not win last time.
    always_comb begin
        // NOTE: default first so every path assigns pick_d and no latch is inferred.
        pick_d = 1'b0;
        if (want_d && !want_i)
            pick_d = 1'b1;
        else if (want_d && want_i)
            pick_d = (D_PRIORITY != 0) ? 1'b1 : !last_grant_d;
    end

    // NOTE: state and latched command use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            op_write     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            grant_d      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (want_i || want_d) begin
                        busy         <= 1'b1;
                        grant_d      <= pick_d;
                        last_grant_d <= pick_d;
                        if (pick_d) begin
                            state    <= SERVE_D;
                            addr_q   <= bus.d_addr;
                            wdata_q  <= bus.d_wdata;
                            op_write <= bus.d_write;
                        end else begin
                            state    <= SERVE_I;
                            addr_q   <= bus.i_addr;
                            wdata_q  <= '0;
                            op_write <= 1'b0;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (bus.mem_ready) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        grant_d <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    grant_d <= 1'b0;
                end
            endcase
        end
    end

    assign serve_i = (state == SERVE_I);
    assign serve_d = (state == SERVE_D);
    assign i_done  = serve_i & bus.mem_ready;
    assign d_done  = serve_d & bus.mem_ready;

    // Commands fall in the completion cycle so memory never sees a second request.
    assign bus.mem_read  = (serve_i | serve_d) & ~op_write & ~bus.mem_ready;
    assign bus.mem_write = (serve_i | serve_d) &  op_write & ~bus.mem_ready;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.i_ready = i_done;
    assign bus.d_ready = d_done;
    assign bus.i_rdata = i_done ? bus.mem_rdata : '0;
    assign bus.d_rdata = d_done ? bus.mem_rdata : '0;
endmodule
